// File: rtl/srv_tcm_ctrl.sv
// srv_tcm_ctrl: dual-port word-interleaved TCM with per-bank round-robin arbitration
// and a fixed 1- or 2-cycle read pipeline per port.
module srv_tcm_ctrl #(
  parameter int DW     = 64,
  parameter int AW     = 16,
  parameter int NBANK  = 2,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_req,
  output logic            a_gnt,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW/8-1:0] a_be,
  input  logic [DW-1:0]   a_wdata,
  output logic            a_rvalid,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_req,
  output logic            b_gnt,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW/8-1:0] b_be,
  input  logic [DW-1:0]   b_wdata,
  output logic            b_rvalid,
  output logic [DW-1:0]   b_rdata
);
  localparam int BW = NBANK > 1 ? $clog2(NBANK) : 1;
  localparam int NB = DW / 8;
  logic [DW-1:0]    mem [2**AW];
  logic [NBANK-1:0] rr;
  logic [BW-1:0]    a_bank, b_bank;
  logic             conflict;
  logic [1:0]       rd, v1, v2;
  logic [DW-1:0]    rd_word [2];
  logic [DW-1:0]    d1 [2];
  logic [DW-1:0]    d2 [2];
  assign a_bank   = NBANK > 1 ? a_addr[BW-1:0] : '0;
  assign b_bank   = NBANK > 1 ? b_addr[BW-1:0] : '0;
  assign conflict = a_req & b_req & (a_bank == b_bank);
  // rr[bank]=0 favours A on a same-bank conflict
  assign a_gnt = reset_n & a_req & (~conflict | ~rr[a_bank]);
  assign b_gnt = reset_n & b_req & (~conflict | rr[b_bank]);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rr <= '0;
    else if (conflict) rr[a_bank] <= ~rr[a_bank];
  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++) begin
      if (a_gnt & a_we & a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      if (b_gnt & b_we & b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  assign rd         = {b_gnt & ~b_we, a_gnt & ~a_we};
  assign rd_word[0] = mem[a_addr];
  assign rd_word[1] = mem[b_addr];
  // data registers only load on a valid beat so rdata holds between responses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v1 <= '0;
      v2 <= '0;
      d1 <= '{default: '0};
      d2 <= '{default: '0};
    end else begin
      v1 <= rd;
      v2 <= v1;
      for (int p = 0; p < 2; p++) begin
        if (rd[p]) d1[p] <= rd_word[p];
        if (v1[p]) d2[p] <= d1[p];
      end
    end
  assign a_rvalid = RD_LAT == 2 ? v2[0] : v1[0];
  assign b_rvalid = RD_LAT == 2 ? v2[1] : v1[1];
  assign a_rdata  = RD_LAT == 2 ? d2[0] : d1[0];
  assign b_rdata  = RD_LAT == 2 ? d2[1] : d1[1];
endmodule

// File: tb/tb_srv_tcm_ctrl.sv
// tb_srv_tcm_ctrl: drives an RD_LAT=1 and an RD_LAT=2 controller with identical stimulus
// and compares both against a transaction-level model of grants, memory and responses.
module tb_srv_tcm_ctrl;
  logic clk = 0, rst_n = 0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [15:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_be = 0, b_be = 0;
  logic [63:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt, b_gnt, a_gnt2, b_gnt2, a_rv1, b_rv1, a_rv2, b_rv2;
  logic [63:0] a_rd1, b_rd1, a_rd2, b_rd2;
  logic [63:0] mm [64];
  bit rrm [2];
  bit rdv [2][4096];
  logic [63:0] rdd [2][4096];
  logic [63:0] last [2][2];
  int e = 0, rst_edge = 0, checks = 0, failures = 0;
  bit ga, gb;

  srv_tcm_ctrl #(.DW(64), .AW(16), .NBANK(2), .RD_LAT(1)) u1 (
    .clk(clk), .reset_n(rst_n),
    .a_req(a_req), .a_gnt(a_gnt), .a_we(a_we), .a_addr(a_addr), .a_be(a_be),
    .a_wdata(a_wdata), .a_rvalid(a_rv1), .a_rdata(a_rd1),
    .b_req(b_req), .b_gnt(b_gnt), .b_we(b_we), .b_addr(b_addr), .b_be(b_be),
    .b_wdata(b_wdata), .b_rvalid(b_rv1), .b_rdata(b_rd1));
  srv_tcm_ctrl #(.DW(64), .AW(16), .NBANK(2), .RD_LAT(2)) u2 (
    .clk(clk), .reset_n(rst_n),
    .a_req(a_req), .a_gnt(a_gnt2), .a_we(a_we), .a_addr(a_addr), .a_be(a_be),
    .a_wdata(a_wdata), .a_rvalid(a_rv2), .a_rdata(a_rd2),
    .b_req(b_req), .b_gnt(b_gnt2), .b_we(b_we), .b_addr(b_addr), .b_be(b_be),
    .b_wdata(b_wdata), .b_rvalid(b_rv2), .b_rdata(b_rd2));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // One clock: inputs are already driven (called right after a falling edge).
  task automatic tick();
    bit conf, ea, eb;
    int ba, bb, g;
    logic av [2][2];
    logic [63:0] ad [2][2];
    bit ev;
    if (!rst_n) begin
      rrm = '{0, 0};
      rst_edge = e;
      last = '{default: '0};
    end
    ba = int'(a_addr[0]);
    bb = int'(b_addr[0]);
    conf = a_req && b_req && ba == bb;
    ea = rst_n && a_req && (!conf || !rrm[ba]);
    eb = rst_n && b_req && (!conf || rrm[bb]);
    #1;
    checks += 4;
    if (a_gnt !== ea) begin failures++; $display("FAIL a_gnt lat1 edge=%0d got=%b exp=%b", e, a_gnt, ea); end
    if (b_gnt !== eb) begin failures++; $display("FAIL b_gnt lat1 edge=%0d got=%b exp=%b", e, b_gnt, eb); end
    if (a_gnt2 !== ea) begin failures++; $display("FAIL a_gnt lat2 edge=%0d got=%b exp=%b", e, a_gnt2, ea); end
    if (b_gnt2 !== eb) begin failures++; $display("FAIL b_gnt lat2 edge=%0d got=%b exp=%b", e, b_gnt2, eb); end
    ga = ea;
    gb = eb;
    @(posedge clk);
    e++;
    rdv[0][e] = ea && !a_we;
    rdv[1][e] = eb && !b_we;
    if (rdv[0][e]) rdd[0][e] = mm[a_addr[5:0]];
    if (rdv[1][e]) rdd[1][e] = mm[b_addr[5:0]];
    for (int i = 0; i < 8; i++) begin
      if (ea && a_we && a_be[i]) mm[a_addr[5:0]][8*i +: 8] = a_wdata[8*i +: 8];
      if (eb && b_we && b_be[i]) mm[b_addr[5:0]][8*i +: 8] = b_wdata[8*i +: 8];
    end
    if (conf && rst_n) rrm[ba] = !rrm[ba];
    @(negedge clk);
    av[0][0] = a_rv1; av[0][1] = a_rv2; av[1][0] = b_rv1; av[1][1] = b_rv2;
    ad[0][0] = a_rd1; ad[0][1] = a_rd2; ad[1][0] = b_rd1; ad[1][1] = b_rd2;
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 2; l++) begin
        g = e - l;
        ev = g > rst_edge && g > 0 && rdv[p][g];
        if (ev) last[p][l] = rdd[p][g];
        checks += 2;
        if (av[p][l] !== ev) begin
          failures++;
          $display("FAIL rvalid port=%0d lat=%0d edge=%0d got=%b exp=%b", p, l + 1, e, av[p][l], ev);
        end
        if (ad[p][l] !== last[p][l]) begin
          failures++;
          $display("FAIL rdata port=%0d lat=%0d edge=%0d got=%h exp=%h", p, l + 1, e, ad[p][l], last[p][l]);
        end
      end
  endtask

  task automatic idle(int n);
    a_req = 0;
    b_req = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    a_req = 1; a_we = 1; a_addr = 16'h0; a_be = 8'hFF; a_wdata = 64'h1111_2222_3333_4444;
    b_req = 1; b_we = 1; b_addr = 16'h2; b_be = 8'hFF; b_wdata = 64'h5555_6666_7777_8888;
    tick();
    tick();
    rst_n = 1;
    tick();
    a_req = 0;
    tick();
    idle(1);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) begin
      a_req = 1; a_we = 1; a_addr = 16'(i); a_be = 8'hFF; a_wdata = {$urandom, $urandom};
      tick();
    end
    idle(1);
  endtask

  task automatic test_diff_bank();
    a_req = 1; a_we = 1; a_addr = 16'h4; a_be = 8'hFF; a_wdata = 64'hA5A5_0404_DEAD_BEEF;
    b_req = 1; b_we = 1; b_addr = 16'h5; b_be = 8'hFF; b_wdata = 64'h5A5A_0505_CAFE_F00D;
    tick();
    checks++;
    if (!(a_gnt && b_gnt) && !(ga && gb)) begin end
    if ({ga, gb} !== 2'b11) begin failures++; $display("FAIL diff_bank_gnt got=%b%b exp=11", ga, gb); end
    a_we = 0; b_we = 0;
    tick();
    idle(1);
    checks += 2;
    if (a_rd2 !== 64'hA5A5_0404_DEAD_BEEF) begin failures++; $display("FAIL diff_bank_a got=%h exp=%h", a_rd2, 64'hA5A5_0404_DEAD_BEEF); end
    if (b_rd2 !== 64'h5A5A_0505_CAFE_F00D) begin failures++; $display("FAIL diff_bank_b got=%h exp=%h", b_rd2, 64'h5A5A_0505_CAFE_F00D); end
  endtask

  task automatic test_conflict();
    string seq = "";
    a_req = 1; a_we = 0; a_addr = 16'h0;
    b_req = 1; b_we = 0; b_addr = 16'h2;
    for (int i = 0; i < 6; i++) begin
      tick();
      seq = {seq, ga ? "A" : (gb ? "B" : "-")};
    end
    idle(2);
    checks++;
    if (seq != "ABABAB" && seq != "BABABA") begin failures++; $display("FAIL conflict_alternate got=%s exp=ABABAB", seq); end
  endtask

  task automatic test_byte_enable();
    a_req = 1; a_we = 1; a_addr = 16'h10; a_be = 8'hFF; a_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    a_be = 8'h0F; a_wdata = 64'h0;
    tick();
    a_we = 0;
    tick();
    checks++;
    if (a_rd1 !== 64'hFFFF_FFFF_0000_0000) begin failures++; $display("FAIL byte_enable got=%h exp=%h", a_rd1, 64'hFFFF_FFFF_0000_0000); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    a_req = 1; a_we = 0;
    for (int i = 0; i < 3; i++) begin
      a_addr = 16'(i);
      tick();
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    a_req = 1; a_we = 0; a_addr = 16'h3;
    tick();
    a_req = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    idle(3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if (ga || !a_req) begin
        a_req = $urandom_range(0, 3) != 0; a_we = 1'($urandom_range(0, 1));
        a_addr = 16'($urandom_range(0, 31)); a_be = 8'($urandom); a_wdata = {$urandom, $urandom};
      end
      if (gb || !b_req) begin
        b_req = $urandom_range(0, 3) != 0; b_we = 1'($urandom_range(0, 1));
        b_addr = 16'($urandom_range(0, 31)); b_be = 8'($urandom); b_wdata = {$urandom, $urandom};
      end
      tick();
    end
    idle(3);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_diff_bank();
    test_conflict();
    test_byte_enable();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
